// File: rtl/dff_bank_write_arbiter.sv
// dff_bank_write_arbiter
// Round-robin write arbiter plus sequential bulk-clear for a bank of
// NUM_ENTRY enabled flop registers. One write per cycle reaches the bank
// through a one-hot entry enable and a shared data bus.
// Optional build macro: DFFARB_REG_OUT_EN registers bank_en/bank_d (one
// extra cycle of latency to the bank); when undefined they are combinational.
module dff_bank_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_ENTRY = 8,
    parameter int WIDTH     = 32,
    localparam int ADDR_W   = $clog2(NUM_ENTRY)
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    input  logic                      clr_start,
    input  logic [WIDTH-1:0]          clr_data,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic [NUM_ENTRY-1:0]      bank_en,
    output logic [WIDTH-1:0]          bank_d
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(NUM_ENTRY - 1);
    localparam logic [PTR_W-1:0]  LAST_REQ   = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [PTR_W-1:0]     rr_ptr;
    logic [ADDR_W-1:0]    clr_cnt;
    logic [WIDTH-1:0]     clr_val;
    logic                 clr_done_q;

    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   ready_vec;
    logic [ADDR_W-1:0]    grant_addr;
    logic [WIDTH-1:0]     grant_data;
    logic [NUM_ENTRY-1:0] wr_en;
    logic [WIDTH-1:0]     wr_d;

    // Round-robin search from rr_ptr upward; blocked entirely while clearing
    // or when a clear is being started this cycle.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        ready_vec = '0;
        idx       = 0;
        cand      = '0;
        if (state_q == IDLE && !clr_start) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                cand = PTR_W'(idx);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_vld) begin
                ready_vec[grant_idx] = 1'b1;
            end
        end
    end

    assign grant_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign grant_data = req_data[grant_idx*WIDTH +: WIDTH];
    assign req_ready  = ready_vec;
    assign clr_busy   = (state_q == CLEAR);
    assign clr_done   = clr_done_q;

    // Bank write selection: clear step wins, otherwise the granted request;
    // an out-of-range address matches no entry so the write is dropped.
    always_comb begin
        wr_en = '0;
        wr_d  = '0;
        if (state_q == CLEAR) begin
            for (int e = 0; e < NUM_ENTRY; e++) begin
                wr_en[e] = (clr_cnt == ADDR_W'(e));
            end
            wr_d = clr_val;
        end else if (grant_vld) begin
            for (int e = 0; e < NUM_ENTRY; e++) begin
                wr_en[e] = (grant_addr == ADDR_W'(e));
            end
            wr_d = grant_data;
        end
    end

    // Next-state logic for the IDLE/CLEAR sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST_ENTRY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer, clear counter/value and done pulse.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            rr_ptr     <= '0;
            clr_cnt    <= '0;
            clr_val    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_vld) begin
                rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == IDLE && clr_start) begin
                clr_val <= clr_data;
                clr_cnt <= '0;
            end else if (state_q == CLEAR) begin
                clr_cnt <= (clr_cnt == LAST_ENTRY) ? '0 : clr_cnt + 1'b1;
            end
            clr_done_q <= (state_q == CLEAR) && (clr_cnt == LAST_ENTRY);
        end
    end

`ifdef DFFARB_REG_OUT_EN
    logic [NUM_ENTRY-1:0] bank_en_q;
    logic [WIDTH-1:0]     bank_d_q;

    // Registered bank outputs; clr_done then coincides with the last
    // registered clear write appearing on bank_en.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            bank_en_q <= '0;
            bank_d_q  <= '0;
        end else begin
            bank_en_q <= wr_en;
            bank_d_q  <= wr_d;
        end
    end

    assign bank_en = bank_en_q;
    assign bank_d  = bank_d_q;
`else
    assign bank_en = wr_en;
    assign bank_d  = wr_d;
`endif

`ifndef SYNTHESIS
    // Sanity checks on the one-hot outputs and the handshake.
    always @(posedge CLK) begin
        if (RSTN) begin
            assert ($onehot0(bank_en));
            assert ($onehot0(req_ready));
            assert ((req_ready & ~req_valid) == '0);
        end
    end
`endif

endmodule
